lector_contador: RTL and testbench
==================================

LECTOR_CONTADOR -- requirements
Module: lector_contador

Interface
REQ-001 The block SHALL have parameter FIFO_UNITS, default 4, giving the number of output-stage FIFOs whose counts are read.
REQ-002 The block SHALL have parameter INDEX, default 2, giving the FIFO index width, equal to log2(FIFO_UNITS).
REQ-003 The block SHALL have parameter TIMEOUT, default 8, giving the maximum cycles to wait for valid per FIFO.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to read all FIFO counts, sampled on the clock edge.
REQ-007 IDLE  input  1  high while all FIFOs are empty.
REQ-008 cuenta  input  5  count value returned by the per-FIFO counter.
REQ-009 valid  input  1  cuenta qualifier, returned combinationally in the same cycle as req.
REQ-010 req  output  1  count request to the counter.
REQ-011 idx  output  INDEX  FIFO being requested.
REQ-012 cuenta_0..cuenta_3  output  5 each  captured count per FIFO.
REQ-013 total  output  7  sum of the four captured counts.
REQ-014 busy  output  1  high while a readout is in progress.
REQ-015 done  output  1  one-cycle pulse when a readout completes successfully.
REQ-016 error  output  1  sticky flag: the readout was aborted.

Function
REQ-017 The block SHALL implement the states ESPERA, SOLICITA and FIN.
REQ-018 In ESPERA, start=1 with IDLE=1 SHALL cause a transition to SOLICITA, clear cuenta_0..3, total and error, and set the index to 0.
REQ-019 In ESPERA, start=1 with IDLE=0 SHALL be ignored, with no state change and no flag change.
REQ-020 req SHALL be 1 exactly when the state is SOLICITA; idx SHALL equal the index register and be 0 outside SOLICITA.
REQ-021 In SOLICITA, when valid=1 at a clock edge, cuenta SHALL be stored into cuenta_<idx>, added into total, and the wait counter cleared.
REQ-022 In SOLICITA, after a capture with idx<FIFO_UNITS-1, idx SHALL increment; after a capture with idx=FIFO_UNITS-1, the state SHALL go to FIN.
REQ-023 Best-case readout latency SHALL be FIFO_UNITS cycles of req=1 followed by one FIN cycle.
REQ-024 In SOLICITA with valid=0, the wait counter SHALL increment; on reaching TIMEOUT, the state SHALL go to ESPERA with error=1.
REQ-025 In SOLICITA, IDLE=0 SHALL abort to ESPERA with error=1 on the next edge; any partial captures are retained.
REQ-026 IDLE=0 SHALL take priority over both valid and the timeout in the same cycle.
REQ-027 In FIN, done SHALL be 1 for exactly one cycle, and the state SHALL then return to ESPERA.
REQ-028 busy SHALL be 1 in SOLICITA and FIN, and 0 in ESPERA.
REQ-029 start asserted while busy=1 SHALL be ignored.
REQ-030 Captured counts and total SHALL hold their values in ESPERA until the next accepted start.
REQ-031 total SHALL be the unsigned sum of the captures; its maximum of 124 fits in 7 bits, so no wrap can occur.
REQ-032 cuenta SHALL be ignored when valid=0.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for clk, force the state to ESPERA and the index and wait counter to 0.
REQ-034 reset=0 SHALL immediately force cuenta_0..3=0, total=0, busy=0, done=0, error=0, req=0 and idx=0.
REQ-035 reset asserted mid-readout SHALL discard the readout with no done pulse; operation SHALL resume only on a new start after reset=1.

Verification
REQ-036 With IDLE=1, start pulse, and valid returned every req cycle with counts 3,0,31,7 -> idx 0,1,2,3 on consecutive cycles; cuenta_0..3=3,0,31,7; total=41; done pulses once; error=0.
REQ-037 start with IDLE=0 -> req stays 0 and busy stays 0 for 10 cycles.
REQ-038 IDLE drops to 0 while idx=2 -> next state ESPERA; error=1; cuenta_0 and cuenta_1 retained; no done pulse.
REQ-039 valid held 0 with idx=1 -> error=1 after 8 cycles of req, then busy=0.
REQ-040 reset pulsed low between clock edges during SOLICITA -> all outputs 0 immediately; a new start afterwards completes normally.
REQ-041 All four counts=31 -> total=124; a second start clears the previous values before the new captures.

Source files
------------

// File: rtl/lector_contador.sv
// Reads the occupancy count of each output-stage FIFO in turn and
// keeps the per-FIFO counts plus their total.
module lector_contador #(
  parameter int FIFO_UNITS = 4,
  parameter int INDEX      = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             IDLE,
  input  logic [4:0]       cuenta,
  input  logic             valid,
  output logic             req,
  output logic [INDEX-1:0] idx,
  output logic [4:0]       cuenta_0,
  output logic [4:0]       cuenta_1,
  output logic [4:0]       cuenta_2,
  output logic [4:0]       cuenta_3,
  output logic [6:0]       total,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    SOLICITA = 2'd1,
    FIN      = 2'd2
  } state_t;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int NSLOT = (FIFO_UNITS > 4) ? FIFO_UNITS : 4;
  localparam logic [INDEX-1:0] LAST = INDEX'(FIFO_UNITS - 1);
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [INDEX-1:0] pos;
  logic [INDEX-1:0] pos_nxt;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_nxt;
  logic [WW-1:0]    wait_inc;
  logic             clear;
  logic             capture;
  logic             abort;
  logic [4:0]       slot [NSLOT];
  logic [6:0]       sum;

  assign wait_inc = wait_cnt + WW'(1);

  // State, index and wait counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ESPERA;
      pos      <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state: IDLE loss beats a capture, a capture beats the timeout
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    wait_nxt  = wait_cnt;
    clear     = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      ESPERA: begin
        if (start && IDLE) begin
          state_nxt = SOLICITA;
          pos_nxt   = '0;
          wait_nxt  = '0;
          clear     = 1'b1;
        end
      end
      SOLICITA: begin
        if (!IDLE) begin
          state_nxt = ESPERA;
          pos_nxt   = '0;
          wait_nxt  = '0;
          abort     = 1'b1;
        end else if (valid) begin
          capture  = 1'b1;
          wait_nxt = '0;
          if (pos == LAST) begin
            state_nxt = FIN;
            pos_nxt   = '0;
          end else begin
            pos_nxt = pos + INDEX'(1);
          end
        end else if (wait_inc == LIMIT) begin
          state_nxt = ESPERA;
          pos_nxt   = '0;
          wait_nxt  = '0;
          abort     = 1'b1;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      FIN: begin
        state_nxt = ESPERA;
      end
      default: begin
        state_nxt = ESPERA;
        pos_nxt   = '0;
        wait_nxt  = '0;
      end
    endcase
  end

  // Captured counts, running total and sticky abort flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot[i] <= '0;
      end
      sum   <= '0;
      error <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NSLOT; i++) begin
        slot[i] <= '0;
      end
      sum   <= '0;
      error <= 1'b0;
    end else begin
      if (capture) begin
        slot[pos] <= cuenta;
        sum       <= sum + {2'b00, cuenta};
      end
      if (abort) begin
        error <= 1'b1;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    req  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    idx  = '0;
    unique case (state)
      SOLICITA: begin
        req  = 1'b1;
        busy = 1'b1;
        idx  = pos;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        req  = 1'b0;
      end
    endcase
  end

  assign cuenta_0 = slot[0];
  assign cuenta_1 = slot[1];
  assign cuenta_2 = slot[2];
  assign cuenta_3 = slot[3];
  assign total    = sum;

endmodule

// File: tb/tb_lector_contador.sv
// Directed bench for lector_contador: table of readouts plus
// hand-written IDLE-loss, IDLE-low start and async reset sequences.
module tb_lector_contador;

  logic       clk;
  logic       reset;
  logic       start;
  logic       IDLE;
  logic [4:0] cuenta;
  logic       valid;
  logic       req;
  logic [1:0] idx;
  logic [4:0] cuenta_0;
  logic [4:0] cuenta_1;
  logic [4:0] cuenta_2;
  logic [4:0] cuenta_3;
  logic [6:0] total;
  logic       busy;
  logic       done;
  logic       error;

  logic [4:0] resp [4];
  logic [3:0] mask;

  int checks;
  int failures;

  typedef struct {
    logic [19:0] counts;
    logic [3:0]  vmask;
    logic [19:0] exp_cnt;
    int          exp_total;
    int          exp_err;
    int          exp_done;
    int          exp_req;
  } vec_t;

  vec_t vecs [6];

  lector_contador #(
    .FIFO_UNITS(4),
    .INDEX(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .IDLE(IDLE),
    .cuenta(cuenta),
    .valid(valid),
    .req(req),
    .idx(idx),
    .cuenta_0(cuenta_0),
    .cuenta_1(cuenta_1),
    .cuenta_2(cuenta_2),
    .cuenta_3(cuenta_3),
    .total(total),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the per-FIFO counter: answers in the same cycle as req
  assign valid  = req && mask[idx];
  assign cuenta = resp[idx];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [19:0] counts, input logic [3:0] m);
    resp[0] = counts[19:15];
    resp[1] = counts[14:10];
    resp[2] = counts[9:5];
    resp[3] = counts[4:0];
    mask    = m;
  endtask

  // Pulse start and follow the readout until busy falls
  task automatic readout(input logic [3:0] m, output int n_req,
                         output int n_done, output int bad_idx,
                         output int hung);
    int stuck;
    int iexp;
    stuck = 4;
    for (int k = 3; k >= 0; k--) begin
      if (!m[k]) stuck = k;
    end
    n_req   = 0;
    n_done  = 0;
    bad_idx = 0;
    hung    = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (req) begin
        iexp = (n_req < stuck) ? n_req : stuck;
        if (int'(idx) != iexp) bad_idx++;
        n_req++;
      end
      if (done) n_done++;
      tick();
    end
    if (busy) hung = 1;
  endtask

  initial begin
    int n_req;
    int n_done;
    int bad_idx;
    int hung;
    int seen_done;
    int seen_act;

    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    IDLE     = 1'b1;
    load(20'h0, 4'b1111);

    vecs[0] = '{{5'd3, 5'd0, 5'd31, 5'd7}, 4'b1111,
                {5'd3, 5'd0, 5'd31, 5'd7}, 41, 0, 1, 4};
    vecs[1] = '{{5'd31, 5'd31, 5'd31, 5'd31}, 4'b1111,
                {5'd31, 5'd31, 5'd31, 5'd31}, 124, 0, 1, 4};
    vecs[2] = '{{5'd1, 5'd2, 5'd3, 5'd4}, 4'b1111,
                {5'd1, 5'd2, 5'd3, 5'd4}, 10, 0, 1, 4};
    vecs[3] = '{{5'd5, 5'd6, 5'd7, 5'd8}, 4'b0001,
                {5'd5, 5'd0, 5'd0, 5'd0}, 5, 1, 0, 9};
    vecs[4] = '{{5'd10, 5'd20, 5'd0, 5'd1}, 4'b1111,
                {5'd10, 5'd20, 5'd0, 5'd1}, 31, 0, 1, 4};
    vecs[5] = '{{5'd12, 5'd13, 5'd14, 5'd15}, 4'b1011,
                {5'd12, 5'd13, 5'd0, 5'd0}, 25, 1, 0, 10};

    #2;
    check("reset_outputs",
          {cuenta_0, cuenta_1, cuenta_2, cuenta_3, total, req, busy,
           done, error, idx},
          32'h0);
    #10;
    reset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].counts, vecs[v].vmask);
      readout(vecs[v].vmask, n_req, n_done, bad_idx, hung);
      check($sformatf("v%0d_hang", v), hung, 0);
      check($sformatf("v%0d_counts", v),
            {cuenta_0, cuenta_1, cuenta_2, cuenta_3},
            vecs[v].exp_cnt);
      check($sformatf("v%0d_total", v), total, vecs[v].exp_total);
      check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      check($sformatf("v%0d_done", v), n_done, vecs[v].exp_done);
      check($sformatf("v%0d_req_cycles", v), n_req, vecs[v].exp_req);
      check($sformatf("v%0d_idx_seq", v), bad_idx, 0);
      tick();
      check($sformatf("v%0d_hold_total", v), total, vecs[v].exp_total);
    end

    // IDLE drops while idx=2: abort, earlier captures kept, no done
    load({5'd9, 5'd8, 5'd7, 5'd6}, 4'b1111);
    seen_done = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drop_idx0", {req, idx}, {1'b1, 2'd0});
    tick();
    check("drop_idx1", {req, idx}, {1'b1, 2'd1});
    tick();
    check("drop_idx2", {req, idx}, {1'b1, 2'd2});
    IDLE = 1'b0;
    tick();
    if (done) seen_done++;
    check("drop_busy", busy, 0);
    check("drop_error", error, 1);
    check("drop_counts", {cuenta_0, cuenta_1, cuenta_2, cuenta_3},
          {5'd9, 5'd8, 5'd0, 5'd0});
    check("drop_total", total, 17);
    tick();
    if (done) seen_done++;
    check("drop_no_done", seen_done, 0);

    // start while IDLE=0 is ignored for 10 cycles
    seen_act = 0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (req || busy || !error) seen_act++;
    end
    start = 1'b0;
    check("idle_low_ignored", seen_act, 0);
    IDLE = 1'b1;
    tick();

    // Async reset between edges during SOLICITA
    load({5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_mid_active", {req, idx}, {1'b1, 2'd1});
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_outputs",
          {cuenta_0, cuenta_1, cuenta_2, cuenta_3, total, req, busy,
           done, error, idx},
          32'h0);
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || busy) seen_done++;
    end
    #3;
    reset = 1'b1;
    tick();
    check("rst_stays_idle", seen_done + int'(busy), 0);
    readout(4'b1111, n_req, n_done, bad_idx, hung);
    check("rst_after_hang", hung, 0);
    check("rst_after_counts", {cuenta_0, cuenta_1, cuenta_2, cuenta_3},
          {5'd4, 5'd3, 5'd2, 5'd1});
    check("rst_after_total", total, 10);
    check("rst_after_done", n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
